// File: rtl/pio_rw_wmem_multi_pkg.sv
// Shared constants, sizing helpers and init-engine state encoding for the
// PIO-accessible wide memory.
package pio_rw_wmem_multi_pkg;

    localparam int PIO_NBITS = 32;

    // Number of PIO words needed to cover one table entry.
    function automatic int calc_nwords(input int width);
        return (width + PIO_NBITS - 1) / PIO_NBITS;
    endfunction

    // Width of the word-index field inside the PIO byte address.
    function automatic int calc_widx_nbits(input int nwords);
        return (nwords <= 1) ? 1 : $clog2(nwords);
    endfunction

    typedef enum logic [1:0] {
        INIT_IDLE = 2'd0,
        INIT_RUN  = 2'd1,
        INIT_DONE = 2'd2
    } init_state_e;

endpackage

// File: rtl/pio_rw_wmem_multi_init_fsm.sv
// Post-reset zero-fill engine: walks every entry once, then reports done.
module pio_wmem_init_fsm
    import pio_rw_wmem_multi_pkg::*;
#(
    parameter int DEPTH_NBITS = 10,
    parameter bit INIT_EN     = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   init_busy_o,
    output logic [DEPTH_NBITS-1:0] init_addr_o,
    output logic                   init_done_o
);

    init_state_e            state_q;
    logic [DEPTH_NBITS-1:0] cnt_q;
    logic                   busy_q;
    logic                   done_q;

    // State, entry counter and registered busy/done flags.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT_EN ? INIT_IDLE : INIT_DONE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= !INIT_EN;
        end else begin
            case (state_q)
                INIT_IDLE: begin
                    state_q <= INIT_RUN;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
                INIT_RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_q <= INIT_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                INIT_DONE: begin
                end
                default: state_q <= INIT_EN ? INIT_IDLE : INIT_DONE;
            endcase
        end
    end

    assign init_busy_o = busy_q;
    assign init_addr_o = cnt_q;
    assign init_done_o = done_q;

endmodule

// File: rtl/ram_1r1w_ultra.sv
// 1R1W table with registered inputs and one cycle of read latency.
module ram_1r1w_ultra #(
    parameter int WIDTH       = 100,
    parameter int DEPTH_NBITS = 10
) (
    input  logic                   clk,
    input  logic                   we_i,
    input  logic [DEPTH_NBITS-1:0] waddr_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   re_i,
    input  logic [DEPTH_NBITS-1:0] raddr_i,
    output logic [WIDTH-1:0]       rdata_o
);

    logic [WIDTH-1:0] mem_q [2**DEPTH_NBITS];
    logic [WIDTH-1:0] rdata_q;

    // Storage write and registered read.
    // NOTE: the storage array has no reset; clearing it is the init engine's job, and a reset branch would stop it mapping onto RAM.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pio_rw_wmem_multi.sv
// PIO-accessible wide memory: entries of WIDTH bits exposed as NWORDS PIO
// words, with the application side always owning the RAM ports first.
module pio_rw_wmem_multi
    import pio_rw_wmem_multi_pkg::*;
#(
    parameter int WIDTH       = 100,
    parameter int DEPTH_NBITS = 10,
    parameter bit REG_WR_EN   = 1'b1,
    parameter bit INIT_EN     = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_div_i,
    input  logic [PIO_NBITS-1:0]   reg_addr_i,
    input  logic [PIO_NBITS-1:0]   reg_din_i,
    input  logic                   reg_rd_i,
    input  logic                   reg_wr_i,
    input  logic                   reg_ms_i,
    input  logic                   app_mem_rd_i,
    input  logic [DEPTH_NBITS-1:0] app_mem_raddr_i,
    input  logic                   app_mem_wr_i,
    input  logic [DEPTH_NBITS-1:0] app_mem_waddr_i,
    input  logic [WIDTH-1:0]       app_mem_wdata_i,
    output logic                   mem_ack_o,
    output logic [PIO_NBITS-1:0]   mem_rdata_o,
    output logic                   app_mem_ack_o,
    output logic [WIDTH-1:0]       app_mem_rdata_o,
    output logic                   init_done_o
);

    localparam int NWORDS    = calc_nwords(WIDTH);
    localparam int WIDX      = calc_widx_nbits(NWORDS);
    localparam int STG_NBITS = PIO_NBITS * (NWORDS - 1);
    localparam int TOP_NBITS = WIDTH - STG_NBITS;
    localparam int SHD_NBITS = PIO_NBITS * NWORDS;
    localparam logic [WIDX-1:0] LAST_IDX = WIDX'(NWORDS - 1);

    // PIO address decode; only the word and entry fields matter.
    logic [WIDX-1:0]        word_idx;
    logic [DEPTH_NBITS-1:0] entry_idx;
    logic                   pio_wr, pio_rd, word_last, word_zero;
    logic                   unused_addr;

    assign word_idx    = reg_addr_i[WIDX+1:2];
    assign entry_idx   = reg_addr_i[WIDX+2 +: DEPTH_NBITS];
    assign pio_wr      = reg_ms_i & reg_wr_i;
    assign pio_rd      = reg_ms_i & reg_rd_i;
    assign word_last   = (word_idx == LAST_IDX);
    assign word_zero   = (word_idx == '0);
    assign unused_addr = ^reg_addr_i;

    // Control state (reset) and datapath state (no reset).
    logic                   app_rd_d1_q, app_wr_d1_q;
    logic [DEPTH_NBITS-1:0] app_raddr_d1_q, app_waddr_d1_q;
    logic [WIDTH-1:0]       app_wdata_d1_q;
    logic                   pw_pend_q, pr_pend_q, rd_app_q, rd_pio_q;
    logic [DEPTH_NBITS-1:0] pw_addr_q, pr_addr_q;
    logic [WIDTH-1:0]       pw_data_q;
    logic [STG_NBITS-1:0]   staging_q;
    logic [SHD_NBITS-1:0]   shadow_q;
    logic                   n_ack_q, mem_ack_q, app_ack_q;
    logic [PIO_NBITS-1:0]   mem_rdata_q, shadow_word;
    logic [WIDTH-1:0]       app_rdata_q;

    logic                   init_busy;
    logic [DEPTH_NBITS-1:0] init_addr;
    logic                   ram_we, ram_re, pw_issue, pr_issue, ack_set;
    logic [DEPTH_NBITS-1:0] ram_waddr, ram_raddr;
    logic [WIDTH-1:0]       ram_wdata, ram_rdata;

    pio_wmem_init_fsm #(
        .DEPTH_NBITS (DEPTH_NBITS),
        .INIT_EN     (INIT_EN)
    ) u_init (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_busy_o (init_busy),
        .init_addr_o (init_addr),
        .init_done_o (init_done_o)
    );

    // Write-port owner: init engine, then application, then deferred PIO commit.
    // NOTE: combinational blocks assign every output a default first so no latch can be inferred.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = app_waddr_d1_q;
        ram_wdata = app_wdata_d1_q;
        pw_issue  = 1'b0;
        if (init_busy) begin
            ram_we    = 1'b1;
            ram_waddr = init_addr;
            ram_wdata = '0;
        end else if (app_wr_d1_q) begin
            ram_we = 1'b1;
        end else if (pw_pend_q) begin
            ram_we    = 1'b1;
            ram_waddr = pw_addr_q;
            ram_wdata = pw_data_q;
            pw_issue  = 1'b1;
        end
    end

    // Read-port owner: application first, deferred PIO word-0 read otherwise.
    assign ram_re    = app_rd_d1_q | pr_pend_q;
    assign ram_raddr = app_rd_d1_q ? app_raddr_d1_q : pr_addr_q;
    assign pr_issue  = pr_pend_q & ~app_rd_d1_q;

    // Ops that complete on decode, plus the two RAM-backed completions.
    assign ack_set = pw_issue | rd_pio_q
                   | (pio_wr & ~(word_last & REG_WR_EN))
                   | (pio_rd & ~word_zero);

    // Shadow word select for reads above word 0; out-of-range words read 0.
    always_comb begin
        shadow_word = '0;
        for (int k = 1; k < NWORDS; k++) begin
            if (word_idx == WIDX'(k)) shadow_word = shadow_q[k*PIO_NBITS +: PIO_NBITS];
        end
    end

    ram_1r1w_ultra #(
        .WIDTH       (WIDTH),
        .DEPTH_NBITS (DEPTH_NBITS)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // Request pipeline, pending flags and the clk_div-gated ack handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            app_rd_d1_q <= 1'b0;
            app_wr_d1_q <= 1'b0;
            rd_app_q    <= 1'b0;
            rd_pio_q    <= 1'b0;
            pw_pend_q   <= 1'b0;
            pr_pend_q   <= 1'b0;
            app_ack_q   <= 1'b0;
            n_ack_q     <= 1'b0;
            mem_ack_q   <= 1'b0;
        end else begin
            app_rd_d1_q <= app_mem_rd_i;
            app_wr_d1_q <= app_mem_wr_i;
            rd_app_q    <= app_rd_d1_q;
            rd_pio_q    <= pr_issue;
            app_ack_q   <= rd_app_q;
            if (pio_wr && word_last && REG_WR_EN) pw_pend_q <= 1'b1;
            else if (pw_issue)                    pw_pend_q <= 1'b0;
            if (pio_rd && word_zero) pr_pend_q <= 1'b1;
            else if (pr_issue)       pr_pend_q <= 1'b0;
            if (ack_set)        n_ack_q <= 1'b1;
            else if (clk_div_i) n_ack_q <= 1'b0;
            if (clk_div_i) mem_ack_q <= n_ack_q;
        end
    end

    // Data registers: staging, commit image, shadow and read data.
    always_ff @(posedge clk) begin
        app_raddr_d1_q <= app_mem_raddr_i;
        app_waddr_d1_q <= app_mem_waddr_i;
        app_wdata_d1_q <= app_mem_wdata_i;
        for (int k = 0; k < NWORDS - 1; k++) begin
            if (pio_wr && word_idx == WIDX'(k)) staging_q[k*PIO_NBITS +: PIO_NBITS] <= reg_din_i;
        end
        if (pio_wr && word_last) begin
            pw_addr_q <= entry_idx;
            pw_data_q <= {reg_din_i[TOP_NBITS-1:0], staging_q};
        end
        if (pio_rd && word_zero) pr_addr_q <= entry_idx;
        if (rd_app_q) app_rdata_q <= ram_rdata;
        if (rd_pio_q) begin
            shadow_q    <= SHD_NBITS'(ram_rdata);
            mem_rdata_q <= ram_rdata[PIO_NBITS-1:0];
        end else if (pio_rd && !word_zero) begin
            mem_rdata_q <= shadow_word;
        end
    end

    assign mem_ack_o       = mem_ack_q;
    assign mem_rdata_o     = mem_rdata_q;
    assign app_mem_ack_o   = app_ack_q;
    assign app_mem_rdata_o = app_rdata_q;

endmodule

// File: tb/tb_pio_rw_wmem_multi.sv
// Directed bench: instance A is the default-style 100-bit table, instance B
// is a 160-bit read-only table (NWORDS=5, so word 5 is out of range).
module tb_pio_rw_wmem_multi;

    localparam int AW = 100;
    localparam int BW = 160;
    localparam int DN = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clk_div = 1'b0;
    logic [31:0]   reg_addr = '0;
    logic [31:0]   reg_din = '0;
    logic          reg_rd = 1'b0, reg_wr = 1'b0, ms_a = 1'b0, ms_b = 1'b0;

    logic          a_rd = 1'b0, a_wr = 1'b0;
    logic [DN-1:0] a_raddr = '0, a_waddr = '0;
    logic [AW-1:0] a_wdata = '0;
    logic          b_rd = 1'b0, b_wr = 1'b0;
    logic [DN-1:0] b_raddr = '0, b_waddr = '0;
    logic [BW-1:0] b_wdata = '0;

    logic          ack_a, ack_b, app_ack_a, app_ack_b, done_a, done_b;
    logic [31:0]   rdata_a, rdata_b;
    logic [AW-1:0] app_rdata_a;
    logic [BW-1:0] app_rdata_b;

    int n_cmp = 0;
    int n_bad = 0;
    int rises_a = 0;
    int misalign_a = 0;

    pio_rw_wmem_multi #(.WIDTH(AW), .DEPTH_NBITS(DN), .REG_WR_EN(1'b1), .INIT_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .clk_div_i(clk_div),
        .reg_addr_i(reg_addr), .reg_din_i(reg_din), .reg_rd_i(reg_rd), .reg_wr_i(reg_wr), .reg_ms_i(ms_a),
        .app_mem_rd_i(a_rd), .app_mem_raddr_i(a_raddr), .app_mem_wr_i(a_wr),
        .app_mem_waddr_i(a_waddr), .app_mem_wdata_i(a_wdata),
        .mem_ack_o(ack_a), .mem_rdata_o(rdata_a), .app_mem_ack_o(app_ack_a),
        .app_mem_rdata_o(app_rdata_a), .init_done_o(done_a)
    );

    pio_rw_wmem_multi #(.WIDTH(BW), .DEPTH_NBITS(DN), .REG_WR_EN(1'b0), .INIT_EN(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .clk_div_i(clk_div),
        .reg_addr_i(reg_addr), .reg_din_i(reg_din), .reg_rd_i(reg_rd), .reg_wr_i(reg_wr), .reg_ms_i(ms_b),
        .app_mem_rd_i(b_rd), .app_mem_raddr_i(b_raddr), .app_mem_wr_i(b_wr),
        .app_mem_waddr_i(b_waddr), .app_mem_wdata_i(b_wdata),
        .mem_ack_o(ack_b), .mem_rdata_o(rdata_b), .app_mem_ack_o(app_ack_b),
        .app_mem_rdata_o(app_rdata_b), .init_done_o(done_b)
    );

    always #5 clk = ~clk;

    // PIO-domain strobe: high one cycle in four, changed on the falling edge.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            ph = (ph + 1) % 4;
            clk_div = (ph == 0);
        end
    end

    // Application traffic must wait for the table to be initialised.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!((a_rd || a_wr) && !done_a)) else $error("app request on A before init_done");
            assert (!((b_rd || b_wr) && !done_b)) else $error("app request on B before init_done");
        end
    end

    // mem_ack on A may only move on an edge where clk_div was high.
    always @(posedge clk) begin
        logic div_seen;
        logic ack_prev;
        div_seen = clk_div;
        ack_prev = ack_a;
        #1;
        if (ack_a !== ack_prev) begin
            if (!div_seen) misalign_a++;
            if (ack_a === 1'b1) rises_a++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pio_wait(input bit sel, output logic [31:0] rdata);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            if ((sel ? ack_b : ack_a) === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        check("ack_seen", 160'(seen), 160'(1));
        rdata = sel ? rdata_b : rdata_a;
        for (int i = 0; i < 64 && (sel ? ack_b : ack_a) === 1'b1; i++) @(negedge clk);
    endtask

    task automatic pio(input bit sel, input bit wr, input logic [31:0] addr,
                       input logic [31:0] din, output logic [31:0] rdata);
        @(negedge clk);
        reg_addr = addr; reg_din = din; reg_wr = wr; reg_rd = !wr;
        ms_a = !sel; ms_b = sel;
        @(negedge clk);
        reg_wr = 1'b0; reg_rd = 1'b0; ms_a = 1'b0; ms_b = 1'b0;
        pio_wait(sel, rdata);
    endtask

    task automatic app_write_a(input logic [DN-1:0] addr, input logic [AW-1:0] data);
        @(negedge clk);
        a_wr = 1'b1; a_waddr = addr; a_wdata = data;
        @(negedge clk);
        a_wr = 1'b0;
    endtask

    // Request in cycle T; ack must be low in T+2 and high with data in T+3.
    task automatic app_read_a(input logic [DN-1:0] addr, input logic [AW-1:0] exp, input string tag);
        @(negedge clk);
        a_rd = 1'b1; a_raddr = addr;
        @(negedge clk);
        a_rd = 1'b0;
        @(negedge clk);
        check({tag, "_early"}, 160'(app_ack_a), 160'(0));
        @(negedge clk);
        check({tag, "_ack"}, 160'(app_ack_a), 160'(1));
        check({tag, "_data"}, 160'(app_rdata_a), 160'(exp));
    endtask

    initial begin
        logic [31:0] rd;
        int n_lat;
        int r0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_done_a", 160'(done_a), 160'(0));
        check("rst_done_b", 160'(done_b), 160'(0));
        check("rst_ack_a", 160'(ack_a), 160'(0));
        check("rst_app_ack_a", 160'(app_ack_a), 160'(0));
        rst_n = 1'b1;

        // 1: init_done 17 edges after release for 16 entries; table reads zero.
        n_lat = 0;
        for (int i = 1; i <= 40 && n_lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (done_a) n_lat = i;
        end
        check("init_latency", 160'(n_lat), 160'(17));
        check("init_done_b", 160'(done_b), 160'(1));
        pio(0, 0, 32'h90, 32'h0, rd);
        check("init_pio_rd", 160'(rd), 160'(0));
        app_read_a(4'd9, '0, "init_app_rd");

        // 2: four-word PIO write, application read-back.
        pio(0, 1, 32'h50, 32'h11111111, rd);
        pio(0, 1, 32'h54, 32'h22222222, rd);
        pio(0, 1, 32'h58, 32'h33333333, rd);
        pio(0, 1, 32'h5C, 32'h0000000F, rd);
        app_read_a(4'd5, 100'hF_33333333_22222222_11111111, "wr5");

        // 3: app write all-ones, PIO word 0 then top word from the shadow.
        app_write_a(4'd7, {AW{1'b1}});
        r0 = rises_a;
        pio(0, 0, 32'h70, 32'h0, rd);
        check("rd70", 160'(rd), 160'(32'hFFFFFFFF));
        check("rd70_one_ack", 160'(rises_a - r0), 160'(1));
        r0 = rises_a;
        pio(0, 0, 32'h7C, 32'h0, rd);
        check("rd7c", 160'(rd), 160'(32'h0000000F));
        check("rd7c_one_ack", 160'(rises_a - r0), 160'(1));

        // 4: PIO read coincident with application read.
        app_write_a(4'd2, 100'h5_AAAA5555_0F0F0F0F_DEADBEEF);
        @(negedge clk);
        reg_addr = 32'h20; reg_rd = 1'b1; ms_a = 1'b1;
        a_rd = 1'b1; a_raddr = 4'd5;
        @(negedge clk);
        reg_rd = 1'b0; ms_a = 1'b0; a_rd = 1'b0;
        @(negedge clk);
        check("coll_app_early", 160'(app_ack_a), 160'(0));
        @(negedge clk);
        check("coll_app_ack", 160'(app_ack_a), 160'(1));
        check("coll_app_data", 160'(app_rdata_a), 160'(100'hF_33333333_22222222_11111111));
        pio_wait(0, rd);
        check("coll_pio_rd20", 160'(rd), 160'(32'hDEADBEEF));
        pio(0, 0, 32'h24, 32'h0, rd);
        check("coll_pio_rd24", 160'(rd), 160'(32'h0F0F0F0F));

        // 5: commit coincident with application write to the same entry.
        pio(0, 1, 32'h30, 32'h01234567, rd);
        pio(0, 1, 32'h34, 32'h89ABCDEF, rd);
        pio(0, 1, 32'h38, 32'h55AA55AA, rd);
        @(negedge clk);
        reg_addr = 32'h3C; reg_din = 32'h7; reg_wr = 1'b1; ms_a = 1'b1;
        a_wr = 1'b1; a_waddr = 4'd3; a_wdata = 100'hABC;
        @(negedge clk);
        reg_wr = 1'b0; ms_a = 1'b0; a_wr = 1'b0;
        pio_wait(0, rd);
        app_read_a(4'd3, 100'h7_55AA55AA_89ABCDEF_01234567, "race3");

        // 6: read-only table B; full write is acked but ignored; word 5 reads 0.
        @(negedge clk);
        b_wr = 1'b1; b_waddr = 4'd6;
        b_wdata = 160'h44444444_33333333_22222222_11111111_CAFEF00D;
        @(negedge clk);
        b_wr = 1'b0;
        pio(1, 1, 32'h40, 32'hA0A0A0A0, rd);
        pio(1, 1, 32'h44, 32'hA1A1A1A1, rd);
        pio(1, 1, 32'h48, 32'hA2A2A2A2, rd);
        pio(1, 1, 32'h4C, 32'hA3A3A3A3, rd);
        pio(1, 1, 32'h50, 32'hA4A4A4A4, rd);
        pio(1, 0, 32'h40, 32'h0, rd);
        check("ro_e2_w0", 160'(rd), 160'(0));
        pio(1, 0, 32'h50, 32'h0, rd);
        check("ro_e2_w4", 160'(rd), 160'(0));
        pio(1, 0, 32'hC0, 32'h0, rd);
        check("ro_e6_w0", 160'(rd), 160'(32'hCAFEF00D));
        pio(1, 0, 32'hD0, 32'h0, rd);
        check("ro_e6_w4", 160'(rd), 160'(32'h44444444));
        pio(1, 0, 32'hD4, 32'h0, rd);
        check("ro_e6_w5", 160'(rd), 160'(0));
        pio(1, 1, 32'hD4, 32'hFFFFFFFF, rd);
        pio(1, 0, 32'hC4, 32'h0, rd);
        check("ro_e6_w1", 160'(rd), 160'(32'h11111111));

        check("ack_align_a", 160'(misalign_a), 160'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
